// File: rtl/ula_multiciclo_if.sv
// Execute-stage ALU bus: operands and START from the control unit, results and handshake back.
interface ula_multiciclo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] hi;
  logic             z;
  logic             v;
  logic             dz;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, input s, hi, z, v, dz, busy, done);
  modport slave  (input start, op, a, b, output s, hi, z, v, dz, busy, done);
endinterface

// File: rtl/ula_multiciclo.sv
// Registered ALU: single-cycle logic/arith/shift ops plus iterative unsigned MULTU/DIVU
// that produce HI/LO over WIDTH cycles, with a START/BUSY/DONE handshake.
module ula_multiciclo #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic              clock,
  input logic              reset_n,
  ula_multiciclo_if.slave  bus
);
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [SHW:0]     cnt;
  logic             is_div;
  logic [WIDTH-1:0] b_q, work_hi, work_lo;
  logic [WIDTH-1:0] s_r, hi_r;
  logic             z_r, v_r, dz_r, done_r;

  logic             multi_op;
  logic [WIDTH-1:0] alu_res, sum, diff;
  logic             alu_v;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub, nx_hi, nx_lo;
  logic             ge;

  assign multi_op = (bus.op == OP_MULTU) || (bus.op == OP_DIVU);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    case (state)
      IDLE: if (bus.start && multi_op) state_nx = RUN;
      RUN:  if (cnt == (SHW+1)'(1))   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = done_r;
    bus.s    = s_r;
    bus.hi   = hi_r;
    bus.z    = z_r;
    bus.v    = v_r;
    bus.dz   = dz_r;
  end

  always_comb begin
    sh      = bus.b[SHW-1:0];
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    alu_res = '0;
    alu_v   = 1'b0;
    case (bus.op)
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_ADD: begin
        alu_res = sum;
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OP_SLL:  alu_res = bus.a << sh;
      OP_SRL:  alu_res = bus.a >> sh;
      OP_SRA:  alu_res = $signed(bus.a) >>> sh;
      default: alu_res = '0;
    endcase
  end

  // One iteration: shift-add for MULTU ({hi,lo} shifts right), restoring subtract for DIVU
  // (remainder in hi, dividend shifting out of lo while quotient bits shift in).
  always_comb begin
    mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_q} : '0);
    rem_sh  = {work_hi, work_lo[WIDTH-1]};
    ge      = (rem_sh >= {1'b0, b_q});
    rem_sub = rem_sh[WIDTH-1:0] - b_q;
    if (is_div) begin
      nx_hi = ge ? rem_sub : rem_sh[WIDTH-1:0];
      nx_lo = {work_lo[WIDTH-2:0], ge};
    end else begin
      nx_hi = mul_sum[WIDTH:1];
      nx_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s_r     <= '0;
      hi_r    <= '0;
      z_r     <= 1'b1;
      v_r     <= 1'b0;
      dz_r    <= 1'b0;
      done_r  <= 1'b0;
      cnt     <= '0;
      is_div  <= 1'b0;
      b_q     <= '0;
      work_hi <= '0;
      work_lo <= '0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE && bus.start) begin
        if (multi_op) begin
          is_div  <= (bus.op == OP_DIVU);
          b_q     <= bus.b;
          work_hi <= '0;
          work_lo <= bus.a;
          cnt     <= (SHW+1)'(WIDTH);
        end else begin
          s_r    <= alu_res;
          z_r    <= (alu_res == '0);
          v_r    <= alu_v;
          dz_r   <= 1'b0;
          done_r <= 1'b1;
        end
      end else if (state == RUN) begin
        work_hi <= nx_hi;
        work_lo <= nx_lo;
        cnt     <= cnt - 1'b1;
        if (cnt == (SHW+1)'(1)) begin
          s_r    <= nx_lo;
          hi_r   <= nx_hi;
          z_r    <= (nx_lo == '0);
          v_r    <= 1'b0;
          dz_r   <= is_div && (b_q == '0);
          done_r <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo at WIDTH=32 with hand-computed expectations.
module tb_ula_multiciclo;
  localparam int WIDTH = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  ula_multiciclo_if #(.WIDTH(WIDTH)) bus ();

  ula_multiciclo #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents an op for exactly one rising edge; returns #1 after that edge.
  task automatic go(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  // Launches a multi-cycle op and waits (bounded) for DONE; optionally pokes START mid-run.
  task automatic run_multi(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit poke, output int done_at, output int busy_n);
    go(op, a, b);
    done_at = -1;
    busy_n  = 0;
    for (int n = 0; n <= 40; n++) begin
      if (bus.done) begin
        done_at = n;
        break;
      end
      if (bus.busy) busy_n++;
      if (poke && n == 10) begin
        bus.start = 1'b1;
        bus.op    = 4'b0010;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int done_at, busy_n, seen;
    bus.start = 1'b0;
    bus.op    = 4'b0000;
    bus.a     = '0;
    bus.b     = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_s",    bus.s,    0);
    check("rst_hi",   bus.hi,   0);
    check("rst_z",    bus.z,    1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);

    go(4'b0010, 32'h7FFF_FFFF, 32'h1);
    check("add_s",    bus.s,    64'h8000_0000);
    check("add_v",    bus.v,    1);
    check("add_z",    bus.z,    0);
    check("add_done", bus.done, 1);
    @(posedge clock);
    #1;
    check("add_done_pulse", bus.done, 0);

    go(4'b0110, 32'd5, 32'd5);
    check("sub_s", bus.s, 0);
    check("sub_z", bus.z, 1);
    check("sub_v", bus.v, 0);

    go(4'b0111, 32'hFFFF_FFFF, 32'd1);
    check("slt_s", bus.s, 1);
    go(4'b1001, 32'hFFFF_FFFF, 32'd1);
    check("sltu_s", bus.s, 0);
    go(4'b0011, 32'hF0F0_1234, 32'h0FF0_1234);
    check("xor_s", bus.s, 64'hFF00_0000);

    go(4'b0100, 32'h8000_0000, 32'd4);
    check("sll_s", bus.s, 0);
    check("sll_z", bus.z, 1);
    go(4'b0101, 32'h8000_0000, 32'd4);
    check("srl_s", bus.s, 64'h0800_0000);
    go(4'b1000, 32'h8000_0000, 32'd4);
    check("sra_s", bus.s, 64'hF800_0000);
    go(4'b1000, 32'h8000_0000, 32'h24);
    check("sra_b24_s", bus.s, 64'hF800_0000);

    run_multi(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, done_at, busy_n);
    check("mul_done_at", done_at, 32);
    check("mul_busy_n",  busy_n,  32);
    check("mul_busy_end", bus.busy, 0);
    check("mul_hi", bus.hi, 64'hFFFF_FFFE);
    check("mul_s",  bus.s,  64'h0000_0001);
    check("mul_z",  bus.z,  0);
    check("mul_v",  bus.v,  0);
    @(posedge clock);
    #1;
    check("mul_done_pulse", bus.done, 0);

    run_multi(4'b1101, 32'd9, 32'd0, 1'b0, done_at, busy_n);
    check("div0_done_at", done_at, 32);
    check("div0_s",  bus.s,  64'hFFFF_FFFF);
    check("div0_hi", bus.hi, 9);
    check("div0_dz", bus.dz, 1);
    check("div0_z",  bus.z,  0);

    run_multi(4'b1101, 32'd100, 32'd7, 1'b0, done_at, busy_n);
    check("div_done_at", done_at, 32);
    check("div_s",  bus.s,  14);
    check("div_hi", bus.hi, 2);
    check("div_dz", bus.dz, 0);
    // Back-to-back: START issued during the DONE cycle.
    bus.start = 1'b1;
    bus.op    = 4'b0010;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    check("b2b_s",    bus.s,    7);
    check("b2b_hi",   bus.hi,   2);
    check("b2b_done", bus.done, 1);
    check("b2b_dz",   bus.dz,   0);

    go(4'b1111, 32'd5, 32'd6);
    check("unk_s",    bus.s,    0);
    check("unk_z",    bus.z,    1);
    check("unk_done", bus.done, 1);
    check("unk_hi",   bus.hi,   2);

    go(4'b1010, 32'd3, 32'd5);
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_s",    bus.s,    0);
    check("midrst_hi",   bus.hi,   0);
    check("midrst_z",    bus.z,    1);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    check("midrst_no_done", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Parametrised, registered successor to the processor's combinational 32-bit ALU.
- Keeps the existing 4-bit operation encoding.
- Adds XOR, shifts, unsigned compare, signed overflow, and iterative unsigned multiply/divide with HI/LO results.
- Sits in the execute stage of the multi-cycle datapath; the control unit drives it with a START/DONE handshake and stalls on BUSY.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width taken from B[SHW-1:0].

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- START  in  1  launch request; sampled only while BUSY=0.
- OP  in  4  operation select, sampled with START.
- A  in  WIDTH  operand A, sampled with START.
- B  in  WIDTH  operand B, sampled with START.
- S  out  WIDTH  result (LO / quotient for multi-cycle ops).
- HI  out  WIDTH  product high half or remainder.
- Z  out  1  S == 0.
- V  out  1  signed overflow (ADD/SUB only).
- DZ  out  1  divide by zero (DIVU only).
- BUSY  out  1  multi-cycle op in progress.
- DONE  out  1  one-cycle pulse: results valid.

Behaviour:
- Reset: one clock is the only clock; reset is synchronous and active-low (reset_n sampled on the rising edge of clock).
- Reset values: while reset_n=0 at an edge, S=0, HI=0, Z=1, V=0, DZ=0, BUSY=0, DONE=0, FSM=IDLE, counter=0.
- Reset mid-operation aborts the op; no DONE is produced.
- Opcodes, A/B signed two's complement unless noted:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, S=1/0); 1100 NOR.
  - 0011 XOR; 0100 SLL; 0101 SRL; 1000 SRA (shift A by B[SHW-1:0]).
  - 1001 SLTU (unsigned).
  - 1010 MULTU: {HI,S} = A*B unsigned.
  - 1101 DIVU: S = A/B, HI = A%B, unsigned.
  - Any other code: S=0, DONE pulses, HI held.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - V=1 when operand signs make signed overflow (ADD: A,B same sign, S differs; SUB: A,B differ, S sign ≠ A sign).
  - V=0 for all other ops.
- FSM states:
  - IDLE: on edge with START=1:
    - single-cycle op: registers S, Z, V, DZ=0 (HI unchanged); DONE=1 next cycle; stays IDLE.
    - MULTU/DIVU: latches operands, counter=WIDTH, BUSY=1, goes to RUN.
  - RUN: one shift-add (MULTU) or restoring-subtract (DIVU) step per edge; counter decrements.
    - On the edge where counter goes 1→0: writes S, HI, Z, DZ; V=0; DONE=1; BUSY=0; returns to IDLE.
- Latency:
  - Single-cycle ops: DONE high in the cycle after the START edge.
  - Multi-cycle ops: DONE high WIDTH cycles after the START edge; BUSY high for exactly WIDTH cycles.
- DONE is a single-cycle pulse. S/HI/Z/V/DZ hold until the next completing op.
- START while BUSY=1 is ignored (no queuing); OP/A/B changes during RUN have no effect.
- START sampled in the cycle DONE=1 is accepted (back-to-back ops allowed).
- DIVU with B=0: runs the full WIDTH cycles; S = all ones, HI = A, DZ=1, Z=0.
- Z is computed from the registered S for every op, including multi-cycle ops.

Test Plan:
- Reset held 2 cycles then released, START=0 → S=0, HI=0, Z=1, BUSY=0, DONE=0; then assert reset_n=0 mid-MULTU → BUSY=0, no DONE.
- Single-cycle ops with WIDTH=32:
  - ADD 0x7FFFFFFF+1 → S=0x80000000, V=1, DONE one cycle after START.
  - SUB 5-5 → S=0, Z=1, V=0.
  - SLT -1<1 → S=1; SLTU 0xFFFFFFFF<1 → S=0.
- Shifts on A=0x80000000, B=4:
  - SLL → 0x00000000, Z=1.
  - SRL → 0x08000000.
  - SRA → 0xF8000000.
  - B=0x24 shifts by 4 (only low 5 bits used).
- MULTU 0xFFFFFFFF*0xFFFFFFFF → HI=0xFFFFFFFE, S=0x00000001; BUSY exactly 32 cycles; DONE on the 32nd cycle; START pulsed during BUSY ignored.
- DIVU 100/7 → S=14, HI=2, DZ=0; DIVU 9/0 → S=0xFFFFFFFF, HI=9, DZ=1.
- Back-to-back: START ADD in the DONE cycle of a DIVU → ADD result next cycle, HI keeps the remainder; unknown OP 1111 → S=0, Z=1, DONE pulses.
